xbus_scheduler: RTL and testbench
=================================

XBUS_SCHEDULER -- requirements
Module: xbus_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of ifmap/filter words; psum width is 2*DATA_WIDTH.
REQ-002 Parameter NUM_COL, default 4, number of PE columns addressed on the X bus; TW = $clog2(NUM_COL).
REQ-003 Parameter BURST_LEN, default 4, maximum consecutive beats one requester holds the bus.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 ifmap_valid / ifmap_ready  in / out  1 / 1  ifmap requester handshake.
REQ-007 ifmap_data / ifmap_tag  in  DATA_WIDTH / TW  ifmap word and destination column tag.
REQ-008 fltr_valid / fltr_ready  in / out  1 / 1  filter requester handshake.
REQ-009 fltr_data / fltr_tag  in  DATA_WIDTH / TW  filter word and tag.
REQ-010 psum_valid / psum_ready  in / out  1 / 1  psum requester handshake.
REQ-011 psum_data / psum_tag  in  2*DATA_WIDTH / TW  psum word and tag.
REQ-012 bus_valid  out  1  X bus beat valid.
REQ-013 bus_type  out  2  0=ifmap, 1=filter, 2=psum; 3 never driven.
REQ-014 bus_data  out  2*DATA_WIDTH  beat payload; ifmap/filter zero-extended.
REQ-015 bus_tag  out  TW  destination tag compared by PEs against their ID.
REQ-016 bus_ready  in  1  PE array accepts the current beat.
REQ-017 beat_cnt  out  3x16 (ifmap, fltr, psum)  accepted-beat counters, wrap at 2^16.

Function
REQ-018 Transfer on requester side occurs when x_valid && x_ready; on bus side when bus_valid && bus_ready.
REQ-019 Bus outputs come from one registered output stage; latency from requester acceptance to bus_valid is exactly 1 cycle.
REQ-020 x_ready = (owner == x) && (state == BUSY) && (!bus_valid || bus_ready); at most one ready high per cycle.
REQ-021 FSM states IDLE and BUSY; IDLE with any valid -> BUSY with owner chosen by round-robin, same cycle ready may not assert (grant takes effect next cycle).
REQ-022 Round-robin order ifmap -> fltr -> psum -> ifmap; search starts after last owner; after reset last owner = psum so ifmap wins first.
REQ-023 In BUSY, burst counter increments per requester-side transfer; on reaching BURST_LEN, or owner valid low while its ready high, state -> IDLE next cycle and last owner updated.
REQ-024 From IDLE re-arbitration costs one bubble cycle; no requester is granted twice in a row while another requester has valid high.
REQ-025 Output stage holds bus_data/bus_type/bus_tag stable while bus_valid && !bus_ready.
REQ-026 bus_valid clears after a bus-side transfer unless a new requester-side transfer occurs in the same cycle (back-to-back, full throughput).
REQ-027 beat_cnt[type] increments on bus-side transfer of that type; 0xFFFF wraps to 0.
REQ-028 Valid dropping before grant is legal; requester data must be held stable only while x_valid && !x_ready.

Reset
REQ-029 rstn low, asynchronously: state=IDLE, last owner=psum, burst counter=0, bus_valid=0, bus_type=0, bus_data=0, bus_tag=0, all ready=0, beat_cnt=0.
REQ-030 Reset mid-burst discards any pending beat in the output stage; no beat counted.
REQ-031 After rstn rises, first arbitration occurs on the first rising edge with rstn high.

Verification
REQ-032 Only ifmap_valid high, 6 beats data 1..6 tag 2, bus_ready=1 -> bus shows 1..4 type 0 tag 2, one bubble, then 5,6; beat_cnt ifmap=6.
REQ-033 All three valid continuously, BURST_LEN=4, bus_ready=1 -> bursts of 4 in order ifmap, fltr, psum, ifmap; one idle cycle between bursts.
REQ-034 psum 0xDEADBEEF with bus_ready low 5 cycles -> bus_data held 0xDEADBEEF, psum_ready low, beat_cnt unchanged until bus_ready high.
REQ-035 fltr data 0x00AB -> bus_data 0x000000AB, bus_type 1.
REQ-036 rstn pulsed low mid-burst with bus_valid=1 -> bus_valid=0 immediately, beat_cnt=0, next grant goes to ifmap.
REQ-037 Preload beat_cnt psum to 0xFFFF via 65535 beats, one more beat -> beat_cnt psum=0.

Source files
------------

// File: rtl/xbus_scheduler.sv
// X bus scheduler: round-robin burst arbitration of ifmap, filter and
// psum requesters onto one registered PE-array bus beat stage.
module xbus_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int BURST_LEN  = 4,
  localparam int TW = $clog2(NUM_COL)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ifmap_valid,
  output logic                    ifmap_ready,
  input  logic [DATA_WIDTH-1:0]   ifmap_data,
  input  logic [TW-1:0]           ifmap_tag,
  input  logic                    fltr_valid,
  output logic                    fltr_ready,
  input  logic [DATA_WIDTH-1:0]   fltr_data,
  input  logic [TW-1:0]           fltr_tag,
  input  logic                    psum_valid,
  output logic                    psum_ready,
  input  logic [2*DATA_WIDTH-1:0] psum_data,
  input  logic [TW-1:0]           psum_tag,
  output logic                    bus_valid,
  output logic [1:0]              bus_type,
  output logic [2*DATA_WIDTH-1:0] bus_data,
  output logic [TW-1:0]           bus_tag,
  input  logic                    bus_ready,
  output logic [2:0][15:0]        beat_cnt
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [2:0]    owner;
  logic [2:0]    last;
  logic [2:0]    vld;
  logic [2:0]    win;
  logic [BW-1:0] burst;
  logic          free;
  logic          grant_on;
  logic          own_valid;
  logic          req_fire;
  logic          bus_fire;
  logic          burst_end;
  logic [1:0]    nxt_type;
  logic [PW-1:0] nxt_data;
  logic [TW-1:0] nxt_tag;

  assign vld       = {psum_valid, fltr_valid, ifmap_valid};
  assign free      = !bus_valid || bus_ready;
  assign grant_on  = (state == BUSY) && free;
  assign own_valid = |(owner & vld);
  assign req_fire  = grant_on && own_valid;
  assign bus_fire  = bus_valid && bus_ready;
  assign burst_end = burst == BW'(BURST_LEN - 1);

  assign ifmap_ready = grant_on && owner[0];
  assign fltr_ready  = grant_on && owner[1];
  assign psum_ready  = grant_on && owner[2];

  // search starts at the requester after the last owner
  always_comb begin
    win = 3'b000;
    unique case (1'b1)
      last[0]: win = vld[1] ? 3'b010 :
                     vld[2] ? 3'b100 : {2'b00, vld[0]};
      last[1]: win = vld[2] ? 3'b100 :
                     vld[0] ? 3'b001 : {1'b0, vld[1], 1'b0};
      default: win = vld[0] ? 3'b001 :
                     vld[1] ? 3'b010 : {vld[2], 2'b00};
    endcase
  end

  always_comb begin
    nxt_type = 2'd0;
    nxt_data = {{DATA_WIDTH{1'b0}}, ifmap_data};
    nxt_tag  = ifmap_tag;
    unique case (1'b1)
      owner[1]: begin
        nxt_type = 2'd1;
        nxt_data = {{DATA_WIDTH{1'b0}}, fltr_data};
        nxt_tag  = fltr_tag;
      end
      owner[2]: begin
        nxt_type = 2'd2;
        nxt_data = psum_data;
        nxt_tag  = psum_tag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      owner <= 3'b001;
      last  <= 3'b100;
      burst <= '0;
    end else begin
      case (state)
        IDLE: if (|vld) begin
          state <= BUSY;
          owner <= win;
          burst <= '0;
        end
        BUSY: if (grant_on) begin
          if (!own_valid || burst_end) begin
            state <= IDLE;
            last  <= owner;
            burst <= '0;
          end else begin
            burst <= burst + BW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_valid <= 1'b0;
      bus_type  <= 2'd0;
      bus_data  <= '0;
      bus_tag   <= '0;
    end else if (req_fire) begin
      bus_valid <= 1'b1;
      bus_type  <= nxt_type;
      bus_data  <= nxt_data;
      bus_tag   <= nxt_tag;
    end else if (bus_fire) begin
      bus_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
    end else if (bus_fire) begin
      case (bus_type)
        2'd0: beat_cnt[0] <= beat_cnt[0] + 16'd1;
        2'd1: beat_cnt[1] <= beat_cnt[1] + 16'd1;
        2'd2: beat_cnt[2] <= beat_cnt[2] + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_scheduler.sv
// Self-checking bench for xbus_scheduler: directed vector table,
// hand sequences, and random traffic against a transaction-level model.
module tb_xbus_scheduler;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifmap_valid, ifmap_ready;
  logic [15:0] ifmap_data;
  logic [1:0]  ifmap_tag;
  logic        fltr_valid, fltr_ready;
  logic [15:0] fltr_data;
  logic [1:0]  fltr_tag;
  logic        psum_valid, psum_ready;
  logic [31:0] psum_data;
  logic [1:0]  psum_tag;
  logic        bus_valid;
  logic [1:0]  bus_type;
  logic [31:0] bus_data;
  logic [1:0]  bus_tag;
  logic        bus_ready;
  logic [2:0][15:0] beat_cnt;

  xbus_scheduler #(
    .DATA_WIDTH(16),
    .NUM_COL(4),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ifmap_valid(ifmap_valid),
    .ifmap_ready(ifmap_ready),
    .ifmap_data(ifmap_data),
    .ifmap_tag(ifmap_tag),
    .fltr_valid(fltr_valid),
    .fltr_ready(fltr_ready),
    .fltr_data(fltr_data),
    .fltr_tag(fltr_tag),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .psum_data(psum_data),
    .psum_tag(psum_tag),
    .bus_valid(bus_valid),
    .bus_type(bus_type),
    .bus_data(bus_data),
    .bus_tag(bus_tag),
    .bus_ready(bus_ready),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [2:0]    v;
    logic [15:0] d;
    logic [1:0]  tg;
    bit          br;
    bit [2:0]    rdy;
    bit          bv;
    logic [1:0]  bt;
    logic [31:0] bd;
  } vec_t;

  vec_t tbl [13];

  int n_cmp = 0;
  int n_bad = 0;

  // transaction-level model state
  bit          m_busy;
  int          m_owner;
  int          m_last;
  int          m_run;
  bit          ev;
  int          et;
  logic [31:0] ed;
  logic [1:0]  etag;
  int          cnt [3];
  bit [2:0]    fired;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int rr(input int lst, input bit [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      int c = (lst + k) % 3;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  task automatic drive(input bit [2:0] v, input logic [15:0] d,
                       input logic [1:0] tg, input bit br);
    ifmap_valid = v[0];
    fltr_valid  = v[1];
    psum_valid  = v[2];
    ifmap_data  = d;
    fltr_data   = d;
    psum_data   = {16'h0, d};
    ifmap_tag   = tg;
    fltr_tag    = tg;
    psum_tag    = tg;
    bus_ready   = br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive(3'b000, 16'h0, 2'd0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 2;
    m_run   = 0;
    ev      = 1'b0;
    et      = 0;
    ed      = '0;
    etag    = '0;
    fired   = '0;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
  endtask

  // called at a negedge right after inputs are driven
  task automatic step();
    bit [2:0]    rdy;
    bit [2:0]    vv;
    bit [2:0]    exp_rdy;
    bit          free;
    bit          rf;
    bit          bf;
    logic [31:0] pd;
    logic [1:0]  pt;
    #1;
    rdy  = {psum_ready, fltr_ready, ifmap_ready};
    vv   = {psum_valid, fltr_valid, ifmap_valid};
    free = !ev || bus_ready;
    exp_rdy = (m_busy && free) ? 3'(1 << m_owner) : 3'b000;
    chk("ready_vec", rdy, exp_rdy);
    rf = m_busy && free && vv[m_owner];
    bf = ev && bus_ready;
    fired = rf ? 3'(1 << m_owner) : 3'b000;
    case (m_owner)
      0: begin pd = {16'h0, ifmap_data}; pt = ifmap_tag; end
      1: begin pd = {16'h0, fltr_data};  pt = fltr_tag;  end
      default: begin pd = psum_data; pt = psum_tag; end
    endcase
    if (bf) cnt[et]++;
    if (rf) begin
      ev = 1'b1; et = m_owner; ed = pd; etag = pt;
    end else if (bf) begin
      ev = 1'b0;
    end
    if (!m_busy) begin
      if (|vv) begin
        m_owner = rr(m_last, vv);
        m_busy  = 1'b1;
        m_run   = 0;
      end
    end else if (free) begin
      if (!vv[m_owner]) begin
        m_busy = 1'b0; m_last = m_owner;
      end else begin
        m_run++;
        if (m_run == BL) begin
          m_busy = 1'b0; m_last = m_owner;
        end
      end
    end
    @(negedge clk);
    chk("bus_valid", bus_valid, ev);
    if (ev) begin
      chk("bus_type", bus_type, et);
      chk("bus_data", bus_data, ed);
      chk("bus_tag", bus_tag, etag);
    end
    for (int k = 0; k < 3; k++)
      chk("beat_cnt", beat_cnt[k], cnt[k] % 65536);
  endtask

  task automatic rand_drive(input bit psum_only);
    if (psum_only) begin
      ifmap_valid = 1'b0;
      fltr_valid  = 1'b0;
    end else begin
      if (!(ifmap_valid && !fired[0])) begin
        ifmap_valid = ($urandom_range(0, 99) < 60);
        ifmap_data  = 16'($urandom);
        ifmap_tag   = 2'($urandom);
      end
      if (!(fltr_valid && !fired[1])) begin
        fltr_valid = ($urandom_range(0, 99) < 60);
        fltr_data  = 16'($urandom);
        fltr_tag   = 2'($urandom);
      end
    end
    if (!(psum_valid && !fired[2])) begin
      psum_valid = psum_only ? 1'b1 : ($urandom_range(0, 99) < 60);
      psum_data  = $urandom;
      psum_tag   = 2'($urandom);
    end
    bus_ready = psum_only ? 1'b1 : ($urandom_range(0, 99) < 75);
  endtask

  initial begin
    int guard;
    bit hit_ffff;
    // ifmap-only 6-beat stream, then a single filter beat
    tbl[0]  = '{3'b001, 16'd1, 2'd2, 1'b1, 3'b000, 1'b0, 2'd0, 32'd0};
    tbl[1]  = '{3'b001, 16'd1, 2'd2, 1'b1, 3'b001, 1'b1, 2'd0, 32'd1};
    tbl[2]  = '{3'b001, 16'd2, 2'd2, 1'b1, 3'b001, 1'b1, 2'd0, 32'd2};
    tbl[3]  = '{3'b001, 16'd3, 2'd2, 1'b1, 3'b001, 1'b1, 2'd0, 32'd3};
    tbl[4]  = '{3'b001, 16'd4, 2'd2, 1'b1, 3'b001, 1'b1, 2'd0, 32'd4};
    tbl[5]  = '{3'b001, 16'd5, 2'd2, 1'b1, 3'b000, 1'b0, 2'd0, 32'd0};
    tbl[6]  = '{3'b001, 16'd5, 2'd2, 1'b1, 3'b001, 1'b1, 2'd0, 32'd5};
    tbl[7]  = '{3'b001, 16'd6, 2'd2, 1'b1, 3'b001, 1'b1, 2'd0, 32'd6};
    tbl[8]  = '{3'b000, 16'd0, 2'd2, 1'b1, 3'b001, 1'b0, 2'd0, 32'd0};
    tbl[9]  = '{3'b000, 16'd0, 2'd2, 1'b1, 3'b000, 1'b0, 2'd0, 32'd0};
    tbl[10] = '{3'b010, 16'hAB, 2'd1, 1'b1, 3'b000, 1'b0, 2'd0, 32'd0};
    tbl[11] = '{3'b010, 16'hAB, 2'd1, 1'b1, 3'b010, 1'b1, 2'd1, 32'hAB};
    tbl[12] = '{3'b000, 16'h0, 2'd1, 1'b1, 3'b010, 1'b0, 2'd0, 32'd0};

    rstn = 1'b0;
    drive(3'b000, 16'h0, 2'd0, 1'b0);
    #12;
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_type", bus_type, 0);
    chk("rst_bus_data", bus_data, 0);
    chk("rst_bus_tag", bus_tag, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_ready", {psum_ready, fltr_ready, ifmap_ready}, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].tg, tbl[i].br);
      #1;
      chk("tbl_ready", {psum_ready, fltr_ready, ifmap_ready}, tbl[i].rdy);
      @(negedge clk);
      chk("tbl_bus_valid", bus_valid, tbl[i].bv);
      if (tbl[i].bv) begin
        chk("tbl_bus_data", bus_data, tbl[i].bd);
        chk("tbl_bus_type", bus_type, tbl[i].bt);
        chk("tbl_bus_tag", bus_tag, tbl[i].tg);
      end
    end
    chk("tbl_cnt_ifmap", beat_cnt[0], 6);
    chk("tbl_cnt_fltr", beat_cnt[1], 1);
    chk("tbl_cnt_psum", beat_cnt[2], 0);

    // all requesters saturated: 4-beat bursts with one idle slot
    do_reset();
    drive(3'b111, 16'h55, 2'd1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("rr_ready", {psum_ready, fltr_ready, ifmap_ready},
          (c % 5 == 0) ? 3'b000 : 3'(1 << ((c / 5) % 3)));
      @(negedge clk);
    end

    // psum beat stalled by the PE array
    do_reset();
    drive(3'b100, 16'h0, 2'd3, 1'b0);
    psum_data = 32'hDEADBEEF;
    #1 chk("stall_idle_rdy", psum_ready, 0);
    @(negedge clk);
    #1 chk("stall_grant_rdy", psum_ready, 1);
    @(negedge clk);
    chk("stall_valid", bus_valid, 1);
    chk("stall_type", bus_type, 2);
    chk("stall_data", bus_data, 32'hDEADBEEF);
    psum_data = 32'h12345678;
    repeat (5) begin
      #1 chk("stall_rdy_low", psum_ready, 0);
      @(negedge clk);
      chk("stall_hold", bus_data, 32'hDEADBEEF);
      chk("stall_cnt", beat_cnt[2], 0);
    end
    bus_ready = 1'b1;
    #1 chk("stall_resume_rdy", psum_ready, 1);
    @(negedge clk);
    chk("b2b_valid", bus_valid, 1);
    chk("b2b_data", bus_data, 32'h12345678);
    chk("b2b_cnt", beat_cnt[2], 1);

    // reset in the middle of an ifmap burst
    do_reset();
    drive(3'b001, 16'h7, 2'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("mid_cnt_pre", beat_cnt[0], 1);
    chk("mid_valid_pre", bus_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", bus_valid, 0);
    chk("mid_rst_cnt", beat_cnt, 0);
    chk("mid_rst_data", bus_data, 0);
    chk("mid_rst_ready", ifmap_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    drive(3'b111, 16'h9, 2'd1, 1'b1);
    #1 chk("mid_arb_rdy", {psum_ready, fltr_ready, ifmap_ready}, 3'b000);
    @(negedge clk);
    #1 chk("mid_first_grant", {psum_ready, fltr_ready, ifmap_ready}, 3'b001);
    @(negedge clk);

    // random traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_drive(1'b0);
      step();
    end

    // psum-only stream until its counter wraps
    guard = 0;
    hit_ffff = 1'b0;
    while (cnt[2] < 65536 && guard < 90000) begin
      rand_drive(1'b1);
      step();
      guard++;
      if (cnt[2] == 65535 && !hit_ffff) begin
        hit_ffff = 1'b1;
        chk("wrap_ffff", beat_cnt[2], 16'hFFFF);
      end
    end
    chk("wrap_reached", cnt[2], 65536);
    chk("wrap_zero", beat_cnt[2], 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
